// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Default number of pipeline freeze cycles per multiply/divide operation
    localparam int MDU_CYCLES_DEF = 32;

    // Controller sequencing state
    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    // Winning priority level, highest priority first
    typedef enum logic [2:0] {
        STALL_DMEM = 3'd0,
        STALL_MDU  = 3'd1,
        STALL_HAZ  = 3'd2,
        REDIRECT   = 3'd3,
        STALL_IMEM = 3'd4,
        NORMAL     = 3'd5
    } prio_t;

endpackage

// File: rtl/mdu_cycle_counter.sv
// Load/decrement down-counter that tracks remaining MDU busy cycles.
// Latency: load/decrement take effect on the next rising edge; last is combinational from the count.
// Backpressure: none; decrements whenever dec is high, independent of pipeline stalls.
module mdu_cycle_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] mdu_cnt;

    // Load takes precedence over decrement; count clears on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt <= '0;
        end else if (load) begin
            mdu_cnt <= load_val;
        end else if (dec) begin
            mdu_cnt <= mdu_cnt - W'(1);
        end
    end

    // Count of one means this is the final busy cycle
    assign last = (mdu_cnt == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised write-enable/flush sequencer for the 5-stage pipeline; PIPE_PERF_CNT_EN adds stall/flush counters.
// Latency: controls are combinational from inputs and state; mdu_busy is a registered state flag.
// Backpressure: dmem stall freezes every stage; MDU freezes front end for MDU_CYCLES cycles; imem not ready bubbles ID.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_has_hazard,
    input  logic hold,
    input  logic branch_has_hazard,
    input  logic mdu_start,
    input  logic imem_ready,
    input  logic dmem_req,
    input  logic dmem_ready,
    output logic pc_write,
    output logic ifid_write,
    output logic ifid_flush,
    output logic idex_write,
    output logic idex_flush,
    output logic exmem_write,
    output logic exmem_flush,
    output logic memwb_write,
    output logic mdu_busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int CNT_BITS = $clog2(MDU_CYCLES);

    state_t state;
    state_t state_next;
    prio_t  level;
    logic   dmem_stall;
    logic   freeze_mdu;
    logic   mdu_load;
    logic   mdu_dec;
    logic   mdu_last;

    assign dmem_stall = dmem_req && !dmem_ready;
    assign freeze_mdu = ((state == RUN) && mdu_start) || (state == MDU_BUSY);
    // MDU entry waits until the data memory stall clears
    assign mdu_load   = (state == RUN) && mdu_start && !dmem_stall;
    // The MDU runs independently of memory, so counting continues through dmem stalls
    assign mdu_dec    = (state == MDU_BUSY);

    mdu_cycle_counter #(
        .W (CNT_BITS)
    ) u_mdu_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mdu_load),
        .dec      (mdu_dec),
        .load_val (CNT_BITS'(MDU_CYCLES - 1)),
        .last     (mdu_last)
    );

    // State register; reset drops any in-flight MDU operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter MDU_BUSY on accepted start, leave on the last counted cycle
    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mdu_load) state_next = MDU_BUSY;
            MDU_BUSY: if (mdu_last) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // Priority resolution, first match wins
    always_comb begin
        level = NORMAL;
        if (dmem_stall)
            level = STALL_DMEM;
        else if (freeze_mdu)
            level = STALL_MDU;
        else if (ld_has_hazard || hold)
            level = STALL_HAZ;
        else if (branch_has_hazard)
            level = REDIRECT;
        else if (!imem_ready)
            level = STALL_IMEM;
    end

    // Per-stage enables from the winning level; reset forces everything low
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_write = 1'b1;
        case (level)
            STALL_DMEM: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                memwb_write = 1'b0;
            end
            STALL_MDU: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
            end
            STALL_HAZ: begin
                // Redirect is dropped here; the branch resolves again next cycle
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
            end
            REDIRECT: begin
                // Wrong-path fetch is abandoned even if imem is not ready
                ifid_flush  = 1'b1;
            end
            STALL_IMEM: begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_write  = 1'b0;
            idex_flush  = 1'b0;
            exmem_write = 1'b0;
            exmem_flush = 1'b0;
            memwb_write = 1'b0;
        end
    end

    assign mdu_busy = (state == MDU_BUSY);

`ifdef PIPE_PERF_CNT_EN
    // Saturating counters for PC-stalled cycles and winning redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if ((level == REDIRECT) && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench with an expected-output queue and an independent negedge monitor.
module tb_pipeline_stall_controller;

    logic clk;
    logic rst_n;
    logic ld_has_hazard, hold, branch_has_hazard, mdu_start;
    logic imem_ready, dmem_req, dmem_ready;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, exmem_flush, memwb_write, mdu_busy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipeline_stall_controller #(
        .MDU_CYCLES (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ld_has_hazard     (ld_has_hazard),
        .hold              (hold),
        .branch_has_hazard (branch_has_hazard),
        .mdu_start         (mdu_start),
        .imem_ready        (imem_ready),
        .dmem_req          (dmem_req),
        .dmem_ready        (dmem_ready),
        .pc_write          (pc_write),
        .ifid_write        (ifid_write),
        .ifid_flush        (ifid_flush),
        .idex_write        (idex_write),
        .idex_flush        (idex_flush),
        .exmem_write       (exmem_write),
        .exmem_flush       (exmem_flush),
        .memwb_write       (memwb_write),
        .mdu_busy          (mdu_busy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order:
    // pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_write, mdu_busy
    localparam logic [8:0] E_RST  = 9'b000000000;
    localparam logic [8:0] E_NORM = 9'b110101010;
    localparam logic [8:0] E_HAZ  = 9'b000111010;
    localparam logic [8:0] E_RED  = 9'b111101010;
    localparam logic [8:0] E_IMEM = 9'b011101010;
    localparam logic [8:0] E_DM0  = 9'b000000000;
    localparam logic [8:0] E_DM1  = 9'b000000001;
    localparam logic [8:0] E_FRZ0 = 9'b000001110;
    localparam logic [8:0] E_FRZ1 = 9'b000001111;

    typedef struct {
        string      name;
        logic [8:0] outs;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    logic [8:0] got;
    assign got = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                  exmem_write, exmem_flush, memwb_write, mdu_busy};

    // Monitor: whenever an expectation is pending, compare at the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if (got !== e.outs) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b (t=%0t)", e.name, got, e.outs, $time);
            end
        end
    end

    // Apply one cycle of inputs (just after the rising edge) and queue its expected outputs
    task automatic step(input logic r, input logic ld, input logic hd, input logic br,
                        input logic ms, input logic im, input logic dq, input logic dr,
                        input logic [8:0] exp_outs, input string nm);
        exp_t e;
        rst_n             = r;
        ld_has_hazard     = ld;
        hold              = hd;
        branch_has_hazard = br;
        mdu_start         = ms;
        imem_ready        = im;
        dmem_req          = dq;
        dmem_ready        = dr;
        e.name = nm;
        e.outs = exp_outs;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        {ld_has_hazard, hold, branch_has_hazard, mdu_start} = 4'hF;
        {imem_ready, dmem_req, dmem_ready} = 3'b111;
        @(posedge clk);
        #1;
        //    rst ld hd br ms im dq dr
        step(0, 1, 1, 1, 1, 1, 1, 0, E_RST,  "reset_all_ones_a");
        step(0, 1, 1, 1, 1, 1, 1, 1, E_RST,  "reset_all_ones_b");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "after_reset_normal");
        step(1, 1, 0, 1, 0, 1, 0, 1, E_HAZ,  "ld_hazard_beats_redirect");
        step(1, 0, 0, 1, 0, 1, 0, 1, E_RED,  "redirect_only");
        step(1, 0, 1, 0, 0, 1, 0, 1, E_HAZ,  "branch_hold");
        step(1, 0, 0, 1, 0, 0, 0, 1, E_RED,  "redirect_imem_not_ready");
        step(1, 0, 0, 0, 0, 0, 0, 1, E_IMEM, "imem_not_ready_alone");
        step(1, 1, 0, 0, 0, 0, 0, 1, E_HAZ,  "hazard_beats_imem");
        step(1, 0, 0, 1, 0, 1, 1, 0, E_DM0,  "dmem_stall_beats_redirect");
        step(1, 0, 0, 0, 0, 1, 1, 1, E_NORM, "dmem_ready_completes");
        // Plain MDU op: 4 freeze cycles, mdu_busy on the last 3
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ0, "mdu_freeze_1");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_freeze_2");
        step(1, 1, 0, 1, 1, 1, 0, 1, E_FRZ1, "mdu_freeze_3_over_hazard");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_freeze_4");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "mdu_release");
        // MDU op with dmem stall mid-operation: release cycle unchanged
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ0, "mdu_dm_freeze_1");
        step(1, 0, 0, 0, 1, 1, 1, 0, E_DM1,  "mdu_dm_stall_1");
        step(1, 0, 0, 0, 1, 1, 1, 0, E_DM1,  "mdu_dm_stall_2");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_dm_freeze_4");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "mdu_dm_release");
        // MDU entry deferred by a dmem stall in RUN
        step(1, 0, 0, 0, 1, 1, 1, 0, E_DM0,  "mdu_entry_deferred");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ0, "mdu_def_freeze_1");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_def_freeze_2");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_def_freeze_3");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_def_freeze_4");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "mdu_def_release");
        // Reset during the second MDU_BUSY cycle
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ0, "mdu_rst_freeze_1");
        step(1, 0, 0, 0, 1, 1, 0, 1, E_FRZ1, "mdu_rst_busy_1");
        step(0, 0, 0, 0, 1, 1, 0, 1, E_RST,  "mdu_rst_async_clear");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "post_rst_run");
        step(1, 0, 0, 0, 0, 1, 0, 1, E_NORM, "post_rst_run_2");

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage MIPS32 pipeline.
- Combines hazard-unit outputs (load-use, branch hold, redirect), a fixed-latency multiply/divide unit (MDU), and instruction/data memory ready signals.
- Produces one prioritized set of per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sits beside the hazard-detection unit and drives the pipeline registers directly.

Parameters:
- MDU_CYCLES, 32, total freeze cycles per MDU operation. Legal range ≥2.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_has_hazard  in  1  load-use hazard, ID vs EX
- hold  in  1  branch operand-not-ready hold from the hazard unit
- branch_has_hazard  in  1  taken branch or jump resolved in ID (redirect)
- mdu_start  in  1  MDU instruction present in EX. Level signal, held while the instruction stays in EX.
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM stage performs a load or store
- dmem_ready  in  1  data memory access completes this cycle
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  load NOP into IF/ID (flush has priority over write)
- idex_write  out  1  ID/EX enable
- idex_flush  out  1  load bubble into ID/EX
- exmem_write  out  1  EX/MEM enable
- exmem_flush  out  1  load bubble into EX/MEM
- memwb_write  out  1  MEM/WB enable
- mdu_busy  out  1  registered, high while the FSM is in MDU_BUSY

Behaviour:
- FSM has two states, RUN and MDU_BUSY.
- A down-counter mdu_cnt is ceil(log2(MDU_CYCLES)) bits wide.
- Reset (rst_n low, asynchronous):
  - state=RUN, mdu_cnt=0.
  - All *_write=0, all *_flush=0, mdu_busy=0, regardless of other inputs.
- RUN → MDU_BUSY: when mdu_start=1 and no dmem stall. Load mdu_cnt=MDU_CYCLES-1.
- MDU_BUSY: mdu_cnt decrements every cycle. When mdu_cnt==1, next state is RUN.
  - mdu_start is ignored in MDU_BUSY.
  - The counter keeps running during dmem stalls, because the MDU is independent.
- freeze_mdu = (state==RUN && mdu_start) || state==MDU_BUSY. This gives MDU_CYCLES freeze cycles in total; the instruction advances on the first cycle back in RUN.
- Outputs are combinational and follow strict priority, first match wins. Anything not listed defaults to write=1, flush=0.
  1. dmem stall (dmem_req && !dmem_ready): every *_write=0, every flush=0. MDU entry from RUN is deferred.
  2. freeze_mdu: pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1, memwb_write=1.
  3. ld_has_hazard || hold: pc_write=0, ifid_write=0, idex_flush=1. Any redirect this cycle is ignored; the branch re-resolves next cycle.
  4. branch_has_hazard: pc_write=1, ifid_flush=1. This applies even if imem_ready=0, so the wrong-path fetch is abandoned.
  5. !imem_ready: pc_write=0, ifid_flush=1 (bubble into ID).
  6. Otherwise all writes=1.
- Reset asserted mid-MDU: returns to RUN immediately. The MDU result is discarded; restarting the MDU is the MDU's own responsibility.
- MDU_CYCLES=2 corner case: exactly one MDU_BUSY cycle.

Optional Feature:
- Macro PIPE_PERF_CNT_EN adds two output ports:
  - stall_cycles [CNT_W-1:0]: increments on any cycle with pc_write=0 outside reset.
  - flush_count [CNT_W-1:0]: increments on each cycle where branch_has_hazard wins priority.
- Both counters saturate at all-ones and reset to 0.
- Without the macro, neither port nor counter exists and the remaining logic is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MDU_BUSY}
  - the priority-level constants (STALL_DMEM, STALL_MDU, STALL_HAZ, REDIRECT, STALL_IMEM, NORMAL)
  - MDU_CYCLES default
- One sub-module, mdu_cycle_counter: load/decrement counter with a last-cycle flag, instantiated once.

Test Plan:
- Reset with all inputs=1 → all writes/flushes 0. After release with no hazards → all writes 1, mdu_busy 0.
- ld_has_hazard=1 for 1 cycle, branch_has_hazard=1 same cycle → pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. Next cycle with redirect only → ifid_flush=1, pc_write=1.
- MDU_CYCLES=4, mdu_start held high → freeze for exactly 4 cycles with exmem_flush=1; mdu_busy high for 3 cycles. Writes return to 1 on cycle 5.
- MDU active and dmem_req=1, dmem_ready=0 for 2 cycles mid-operation → all writes 0 during stall. MDU release cycle is unchanged (counter not paused).
- imem_ready=0 with branch_has_hazard=1 → pc_write=1, ifid_flush=1. imem_ready=0 alone → pc_write=0, ifid_flush=1.
- rst_n deasserted low during cycle 2 of MDU_BUSY → mdu_busy=0 immediately. After release, state=RUN with normal writes.
